// File: rtl/swt_obs_unload.sv
// SWT observation reader: captures the observation vector, folds each capture into a
// rotating MISR signature, and serially unloads either value over a valid/ready link.
module swt_obs_unload #(
  parameter int OBS_FLOP_NUM  = 4,
  parameter int CNT_W         = 8,
  parameter int SER_LSB_FIRST = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [OBS_FLOP_NUM-1:0] ObsIn,
  input  logic                    Capture,
  input  logic                    ClearSig,
  input  logic                    Unload,
  input  logic                    UnloadSel,
  output logic                    SerOut,
  output logic                    SerValid,
  input  logic                    SerReady,
  output logic                    SerLast,
  output logic                    Done,
  output logic                    Busy,
  output logic [OBS_FLOP_NUM-1:0] SigOut,
  output logic [CNT_W-1:0]        CaptureCount
);

  localparam int BW = (OBS_FLOP_NUM > 1) ? $clog2(OBS_FLOP_NUM) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(OBS_FLOP_NUM - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [OBS_FLOP_NUM-1:0] cap_q, cap_d;
  logic [OBS_FLOP_NUM-1:0] sig_q, sig_d;
  logic [OBS_FLOP_NUM-1:0] shift_q, shift_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;

  logic [OBS_FLOP_NUM-1:0] sig_rot;
  logic                    accept;
  logic                    last_beat;
  logic                    ser_bit;

  // Signature rotates left by one before the new observation is folded in.
  if (OBS_FLOP_NUM == 1) begin : g_rot_one
    assign sig_rot = sig_q;
  end else begin : g_rot_many
    assign sig_rot = {sig_q[OBS_FLOP_NUM-2:0], sig_q[OBS_FLOP_NUM-1]};
  end

  if (SER_LSB_FIRST != 0) begin : g_lsb
    assign ser_bit = shift_q[0];
  end else begin : g_msb
    assign ser_bit = shift_q[OBS_FLOP_NUM-1];
  end

  assign accept    = (state_q == ST_SHIFT) && SerReady;
  assign last_beat = (bit_cnt_q == LAST_IDX);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d   = state_q;
    cap_d     = cap_q;
    sig_d     = sig_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    done_d    = accept && last_beat;

    if (Capture) cap_d = ObsIn;

    if (ClearSig) begin
      sig_d = Capture ? ObsIn : '0;
      cnt_d = Capture ? CNT_W'(1) : '0;
    end else if (Capture) begin
      sig_d = sig_rot ^ ObsIn;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    // Unload loads from the pre-capture registers, so a same-cycle Capture never leaks in.
    case (state_q)
      ST_IDLE: begin
        if (Unload) begin
          shift_d   = UnloadSel ? sig_q : cap_q;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          shift_d   = (SER_LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_beat) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state_q   <= ST_IDLE;
      cap_q     <= '0;
      sig_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      sig_q     <= sig_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign SerValid     = (state_q == ST_SHIFT);
  assign Busy         = (state_q == ST_SHIFT);
  assign SerOut       = SerValid & ser_bit;
  assign SerLast      = SerValid & last_beat;
  assign Done         = done_q;
  assign SigOut       = sig_q;
  assign CaptureCount = cnt_q;

endmodule

// File: tb/tb_swt_obs_unload.sv
// Scoreboard bench for swt_obs_unload: a frame-level reference model queues expected
// beats on each accepted Unload; a negedge monitor compares every presented beat.
module tb_swt_obs_unload;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [N-1:0]  obs;
  logic          capture, clear_sig, unload, unload_sel, ser_ready;
  logic          ser_out, ser_valid, ser_last, done, busy;
  logic [N-1:0]  sig_out;
  logic [CW-1:0] cap_count;

  swt_obs_unload #(.OBS_FLOP_NUM(N), .CNT_W(CW), .SER_LSB_FIRST(1)) dut (
    .Clock(clk), .Reset(rst), .ObsIn(obs), .Capture(capture), .ClearSig(clear_sig),
    .Unload(unload), .UnloadSel(unload_sel), .SerOut(ser_out), .SerValid(ser_valid),
    .SerReady(ser_ready), .SerLast(ser_last), .Done(done), .Busy(busy),
    .SigOut(sig_out), .CaptureCount(cap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit b; bit last; } beat_t;
  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the unit, updated on each rising edge.
  logic [N-1:0] m_cap, m_sig, m_val;
  int           m_cnt, m_acc;
  bit           m_busy, m_done, was_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_cap = '0; m_sig = '0; m_cnt = 0; m_busy = 0; m_acc = 0; m_done = 0;
      exp_q.delete();
    end else begin
      was_busy = m_busy;
      m_done   = 0;
      if (m_busy && ser_ready) begin
        m_acc++;
        if (m_acc == N) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (!was_busy && unload) begin
        m_val = unload_sel ? m_sig : m_cap;
        for (int k = 0; k < N; k++) exp_q.push_back('{b: m_val[k], last: (k == N - 1)});
        m_busy = 1;
        m_acc  = 0;
      end
      if (clear_sig) begin
        m_sig = capture ? obs : '0;
        m_cnt = capture ? 1 : 0;
      end else if (capture) begin
        m_sig = N'((m_sig << 1) | (m_sig >> (N - 1))) ^ obs;
        m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
      end
      if (capture) m_cap = obs;
    end
  end

  // Monitor: compares everything the DUT presents, away from the active edge.
  always @(negedge clk) begin
    check("ser_valid", ser_valid, m_busy);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("sig_out", sig_out, m_sig);
    check("capture_count", cap_count, m_cnt);
    if (!ser_valid) begin
      check("ser_out_idle", ser_out, 0);
      check("ser_last_idle", ser_last, 0);
    end else if (exp_q.size() == 0) begin
      check("unexpected_beat", 1, 0);
    end else begin
      check("ser_out", ser_out, exp_q[0].b);
      check("ser_last", ser_last, exp_q[0].last);
      if (ser_ready && !rst) void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    capture = 0; clear_sig = 0; unload = 0; unload_sel = 0;
  endtask

  int n;
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    rst = 1; obs = '0; ser_ready = 0; quiet();
    tick(); tick();
    rst = 0;
    check("rst_valid", ser_valid, 0);
    check("rst_count", cap_count, 0);
    check("rst_sig", sig_out, 0);

    // Signature build-up from two captures.
    clear_sig = 1; tick(); clear_sig = 0;
    capture = 1; obs = 4'b0101; tick();
    check("sig_first", sig_out, 4'b0101);
    obs = 4'b0011; tick(); capture = 0;
    check("sig_second", sig_out, 4'b1001);
    check("count_two", cap_count, 2);

    // Signature unload with ready tied high.
    ser_ready = 1; unload = 1; unload_sel = 1; tick(); quiet();
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    check("busy_cycles", n, 4);
    check("done_pulse", done, 1);
    tick();
    check("done_one_cycle", done, 0);

    // Capture unload under back-pressure.
    unload = 1; unload_sel = 0; ser_ready = 0; tick(); quiet();
    for (int i = 0; i < 7; i++) begin ser_ready = pat[i][0]; tick(); end
    check("stall_done", done, 1);
    check("stall_idle", busy, 0);

    // Same-cycle Capture + Unload, then an ignored mid-frame Unload.
    ser_ready = 1; unload = 1; unload_sel = 0; capture = 1; obs = 4'b1111; tick(); quiet();
    tick();
    unload = 1; tick(); unload = 0;
    tick(); tick();
    check("overlap_done", done, 1);
    unload = 1; unload_sel = 0; tick(); quiet();
    for (int i = 0; i < 4; i++) tick();
    check("new_capture_frame_done", done, 1);

    // ClearSig + Capture, then counter saturation.
    clear_sig = 1; capture = 1; obs = 4'b1000; tick(); quiet();
    check("clear_capture_sig", sig_out, 4'b1000);
    check("clear_capture_cnt", cap_count, 1);
    for (int i = 0; i < 5; i++) begin capture = 1; obs = N'($urandom); tick(); end
    quiet();
    check("count_saturated", cap_count, 3);

    // Reset on the second beat of a frame.
    unload = 1; unload_sel = 1; ser_ready = 1; tick(); quiet();
    tick();
    rst = 1; tick(); rst = 0;
    check("abort_valid", ser_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sig", sig_out, 0);
    check("abort_count", cap_count, 0);
    unload = 1; tick(); quiet();
    for (int i = 0; i < 4; i++) tick();
    check("post_reset_frame_done", done, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(199) == 0);
      capture    = ($urandom_range(9) < 3);
      clear_sig  = ($urandom_range(19) == 0);
      unload     = ($urandom_range(4) == 0);
      unload_sel = 1'($urandom);
      ser_ready  = ($urandom_range(9) < 6);
      obs        = N'($urandom);
      tick();
    end

    rst = 0; quiet(); ser_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
